rat_intc: RTL

- Interrupt controller that drives the `interrupt` input of the RAT control unit. It is the requesting end of the interrupt handshake the control unit services.
- Collects up to 8 peripheral request lines, edge-detects and latches them as pending, and applies a mask and fixed priority.
- Holds `interrupt` high until the control unit acknowledges entry to its interrupt state, then records the cause.
- Mask, pending and cause registers are reachable from software through the existing IN/OUT port bus (`port_id`, `out_port`, `io_strb`).

---
 rtl/rat_intc.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rat_intc.sv
// Interrupt controller for the RAT control unit: edge-detected, masked, fixed-priority requests
// with an int_ack handshake. Define RAT_INTC_SYNC_EN to add a 2-flop synchronizer on irq_in.
module rat_intc #(
    parameter int unsigned N_SRC   = 8,
    parameter logic [7:0]  BASE_ID = 8'h30,
    parameter int unsigned HOLDOFF = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             int_ack,
    input  logic [7:0]       port_id,
    input  logic [7:0]       out_port,
    input  logic             io_strb,
    output logic [7:0]       in_port,
    output logic             in_sel,
    output logic             interrupt
);

    localparam logic [7:0] PEND_ID   = BASE_ID + 8'd1;
    localparam logic [7:0] CAUSE_ID  = BASE_ID + 8'd2;
    localparam logic [2:0] HOLD_LOAD = 3'(HOLDOFF);

    typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [7:0]       cause_q, cause_d;
    logic [N_SRC-1:0] irq_prev_q;
    logic [N_SRC-1:0] irq_s;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] act;
    logic [N_SRC-1:0] sel_bit;
    logic [N_SRC-1:0] clr;
    logic [2:0]       sel;
    logic             any;
    logic             take;
    logic             wr_mask;
    logic             wr_pend;

`ifdef RAT_INTC_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in;
`endif

    assign rise    = irq_s & ~irq_prev_q;
    assign act     = pending_q & mask_q;
    assign any     = |act;
    assign wr_mask = io_strb && (port_id == BASE_ID);
    assign wr_pend = io_strb && (port_id == PEND_ID);

    // Descending scan so the lowest active index is the one left standing.
    always_comb begin
        sel     = '0;
        sel_bit = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (act[i]) begin
                sel        = 3'(i);
                sel_bit    = '0;
                sel_bit[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any) state_d = StReq;
            end
            StReq: begin
                if (!any) begin
                    state_d = StIdle;
                end else if (int_ack) begin
                    take    = 1'b1;
                    cnt_d   = HOLD_LOAD;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q <= 3'd1) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // A new edge outranks any clear landing on the same bit in the same cycle.
    always_comb begin
        clr = '0;
        if (wr_pend) clr = clr | out_port[N_SRC-1:0];
        if (take)    clr = clr | sel_bit;
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = wr_mask ? out_port[N_SRC-1:0] : mask_q;
        cause_d   = cause_q;
        if (take) begin
            cause_d = {1'b1, 4'b0000, sel};
        end else if (wr_pend) begin
            cause_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mask_q     <= '0;
            pending_q  <= '0;
            cause_q    <= '0;
            irq_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            pending_q  <= pending_d;
            cause_q    <= cause_d;
            irq_prev_q <= irq_s;
        end
    end

    assign interrupt = (state_q == StReq);

    always_comb begin
        in_port = '0;
        in_sel  = 1'b0;
        if (port_id == BASE_ID) begin
            in_port[N_SRC-1:0] = mask_q;
            in_sel             = 1'b1;
        end else if (port_id == PEND_ID) begin
            in_port[N_SRC-1:0] = pending_q;
            in_sel             = 1'b1;
        end else if (port_id == CAUSE_ID) begin
            in_port = cause_q;
            in_sel  = 1'b1;
        end
    end

endmodule
